// File: rtl/piece_move_controller.sv
// -----------------------------------------------------------------------------
// piece_move_controller
//
// Owns the active piece's column (XPOS), row (YPOS) and orientation code
// (currentBlock). Movement requests (gravity, left, right, rotate) are latched
// into pending flags. They are serialised one at a time through the registered
// collision-checker bank: issue a check, wait one cycle for the verdict, then
// commit or discard the move. A failed gravity move raises a one-cycle lock
// pulse, and the controller then waits for the next piece to spawn.
//
// Optional feature macro: HARD_DROP_EN
//   When defined, adds input hardDropReq. A hard drop repeats down-checks
//   until one fails or the floor is reached, and then locks the piece.
//
// Parameters
//   SPAWN_X      column loaded on spawn
//   MAX_Y        lowest legal row
//
// Ports
//   Clock        in   system clock, rising edge
//   Reset        in   synchronous active-high reset
//   leftReq      in   pulse: move left
//   rightReq     in   pulse: move right
//   rotReq       in   pulse: rotate clockwise
//   dropTick     in   pulse: gravity step
//   spawnValid   in   new piece available (honoured only while spawning)
//   spawnBlock   in   [3:0] code of the new piece
//   canMove      in   checker verdict, valid one cycle after checkEnable
//   hardDropReq  in   pulse: hard drop (HARD_DROP_EN only)
//   checkEnable  out  one-cycle checker enable
//   checkDir     out  [1:0] 0 down, 1 left, 2 right, 3 rotate
//   checkBlock   out  [3:0] code presented to the checker
//   XPOS         out  [3:0] piece column
//   YPOS         out  [4:0] piece row
//   currentBlock out  [3:0] piece code
//   lockPulse    out  one-cycle pulse: the piece has landed
//   busy         out  high in every state except idle
// -----------------------------------------------------------------------------
module piece_move_controller #(
  parameter int SPAWN_X = 6,
  parameter int MAX_Y   = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       leftReq,
  input  logic       rightReq,
  input  logic       rotReq,
  input  logic       dropTick,
  input  logic       spawnValid,
  input  logic [3:0] spawnBlock,
  input  logic       canMove,
`ifdef HARD_DROP_EN
  input  logic       hardDropReq,
`endif
  output logic       checkEnable,
  output logic [1:0] checkDir,
  output logic [3:0] checkBlock,
  output logic [3:0] XPOS,
  output logic [4:0] YPOS,
  output logic [3:0] currentBlock,
  output logic       lockPulse,
  output logic       busy
);

  localparam logic [3:0] SPAWN_X_L = 4'(SPAWN_X);
  localparam logic [4:0] MAX_Y_L   = 5'(MAX_Y);
  localparam logic [3:0] MAX_X_L   = 4'd12;

  // Pending-flag indices equal the checker select code of the request.
  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_ROT   = 2'd3;

  typedef enum logic [2:0] {
    ST_SPAWN = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_LOCK  = 3'd4
  } state_e;

  // Clockwise rotation map of the piece codes.
  function automatic logic [3:0] rotate_code(input logic [3:0] blk);
    logic [3:0] nxt;
    case (blk)
      4'd0:    nxt = 4'd1;
      4'd1:    nxt = 4'd0;
      4'd2:    nxt = 4'd2;
      4'd3:    nxt = 4'd4;
      4'd4:    nxt = 4'd3;
      4'd5:    nxt = 4'd6;
      4'd6:    nxt = 4'd7;
      4'd7:    nxt = 4'd8;
      4'd8:    nxt = 4'd5;
      4'd9:    nxt = 4'd10;
      4'd10:   nxt = 4'd11;
      4'd11:   nxt = 4'd12;
      4'd12:   nxt = 4'd9;
      4'd13:   nxt = 4'd14;
      4'd14:   nxt = 4'd13;
      default: nxt = 4'd15;
    endcase
    return nxt;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] pend_q, pend_d;          // [0] drop, [1] left, [2] right, [3] rot
  logic       hard_pend_q, hard_pend_d;
  logic       hard_act_q, hard_act_d;  // current down-check belongs to a hard drop
  logic [3:0] xpos_q, xpos_d;
  logic [4:0] ypos_q, ypos_d;
  logic [3:0] blk_q, blk_d;
  logic       chk_en_q, chk_en_d;
  logic [1:0] chk_dir_q, chk_dir_d;
  logic [3:0] chk_blk_q, chk_blk_d;
  logic       lock_q, lock_d;
  logic       busy_q, busy_d;

  logic [3:0] req_s;
  logic       hard_s;
  logic       hard_req_s;

`ifdef HARD_DROP_EN
  assign hard_req_s = hardDropReq;
`else
  assign hard_req_s = 1'b0;
`endif

  // Next-state, pending-flag and position logic.
  always_comb begin
    state_d     = state_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    blk_d       = blk_q;
    chk_dir_d   = chk_dir_q;
    chk_blk_d   = chk_blk_q;
    hard_act_d  = hard_act_q;

    // Pulses merge into the flags in every state; a repeat pulse is absorbed.
    req_s       = pend_q | {rotReq, rightReq, leftReq, dropTick};
    hard_s      = hard_pend_q | hard_req_s;
    pend_d      = req_s;
    hard_pend_d = hard_s;

    case (state_q)
      ST_SPAWN: begin
        if (spawnValid) begin
          blk_d       = spawnBlock;
          xpos_d      = SPAWN_X_L;
          ypos_d      = 5'd0;
          pend_d      = 4'd0;
          hard_pend_d = 1'b0;
          hard_act_d  = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_SPAWN;
        end
      end

      ST_IDLE: begin
        // Pulses arriving this cycle take part in arbitration directly.
        if (hard_s) begin
          if (ypos_q == MAX_Y_L) begin
            hard_pend_d = 1'b0;
            state_d     = ST_LOCK;
          end else begin
            hard_act_d = 1'b1;
            chk_dir_d  = DIR_DOWN;
            chk_blk_d  = blk_q;
            state_d    = ST_ISSUE;
          end
        end else if (req_s[DIR_DOWN]) begin
          if (ypos_q == MAX_Y_L) begin
            // Already on the floor: no check, lock straight away.
            pend_d[DIR_DOWN] = 1'b0;
            state_d          = ST_LOCK;
          end else begin
            hard_act_d = 1'b0;
            chk_dir_d  = DIR_DOWN;
            chk_blk_d  = blk_q;
            state_d    = ST_ISSUE;
          end
        end else if (req_s[DIR_ROT]) begin
          hard_act_d = 1'b0;
          chk_dir_d  = DIR_ROT;
          chk_blk_d  = rotate_code(blk_q);
          state_d    = ST_ISSUE;
        end else if (req_s[DIR_LEFT] && req_s[DIR_RIGHT]) begin
          // Opposing horizontal requests cancel each other.
          pend_d[DIR_LEFT]  = 1'b0;
          pend_d[DIR_RIGHT] = 1'b0;
          state_d           = ST_IDLE;
        end else if (req_s[DIR_LEFT]) begin
          hard_act_d = 1'b0;
          chk_dir_d  = DIR_LEFT;
          chk_blk_d  = blk_q;
          state_d    = ST_ISSUE;
        end else if (req_s[DIR_RIGHT]) begin
          hard_act_d = 1'b0;
          chk_dir_d  = DIR_RIGHT;
          chk_blk_d  = blk_q;
          state_d    = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        // Winner's flag clears; a same-cycle repeat pulse is absorbed.
        if (hard_act_q) begin
          hard_pend_d = 1'b0;
        end else begin
          pend_d[chk_dir_q] = 1'b0;
        end
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (canMove) begin
          // Commit with saturation at the board edges.
          case (chk_dir_q)
            DIR_DOWN: begin
              if (ypos_q != MAX_Y_L) begin
                ypos_d = ypos_q + 5'd1;
              end else begin
                ypos_d = ypos_q;
              end
            end
            DIR_LEFT: begin
              if (xpos_q != 4'd0) begin
                xpos_d = xpos_q - 4'd1;
              end else begin
                xpos_d = xpos_q;
              end
            end
            DIR_RIGHT: begin
              if (xpos_q != MAX_X_L) begin
                xpos_d = xpos_q + 4'd1;
              end else begin
                xpos_d = xpos_q;
              end
            end
            DIR_ROT: begin
              blk_d = rotate_code(blk_q);
            end
            default: begin
              blk_d = blk_q;
            end
          endcase
          if (hard_act_q) begin
            // Hard drop keeps probing until it reaches the floor.
            if (ypos_d == MAX_Y_L) begin
              state_d = ST_LOCK;
            end else begin
              state_d = ST_ISSUE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else if (chk_dir_q == DIR_DOWN) begin
          state_d = ST_LOCK;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOCK: begin
        state_d = ST_SPAWN;
      end

      default: begin
        state_d = ST_SPAWN;
      end
    endcase

    // Outputs are registered from the upcoming state so they align with it.
    chk_en_d = (state_d == ST_ISSUE);
    lock_d   = (state_d == ST_LOCK);
    busy_d   = (state_d != ST_IDLE);
  end

  // State, position and registered-output flops.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_SPAWN;
      pend_q      <= 4'd0;
      hard_pend_q <= 1'b0;
      hard_act_q  <= 1'b0;
      xpos_q      <= SPAWN_X_L;
      ypos_q      <= 5'd0;
      blk_q       <= 4'd0;
      chk_en_q    <= 1'b0;
      chk_dir_q   <= 2'd0;
      chk_blk_q   <= 4'd0;
      lock_q      <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      hard_pend_q <= hard_pend_d;
      hard_act_q  <= hard_act_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      blk_q       <= blk_d;
      chk_en_q    <= chk_en_d;
      chk_dir_q   <= chk_dir_d;
      chk_blk_q   <= chk_blk_d;
      lock_q      <= lock_d;
      busy_q      <= busy_d;
    end
  end

  assign checkEnable  = chk_en_q;
  assign checkDir     = chk_dir_q;
  assign checkBlock   = chk_blk_q;
  assign XPOS         = xpos_q;
  assign YPOS         = ypos_q;
  assign currentBlock = blk_q;
  assign lockPulse    = lock_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_piece_move_controller.sv
// Self-checking bench for piece_move_controller: directed scenarios with
// literal expectations plus weighted random stimulus, all compared each cycle
// against a behavioural model of the piece sequencer.
module tb_piece_move_controller;

  localparam int SPAWN_X = 6;
  localparam int MAX_Y   = 16;
  localparam int MAX_X   = 12;

  localparam int PH_SPAWN = 0;
  localparam int PH_IDLE  = 1;
  localparam int PH_CHECK = 2;  // check enable presented this cycle
  localparam int PH_VERD  = 3;  // verdict awaited this cycle
  localparam int PH_LAND  = 4;

  logic       Clock;
  logic       Reset;
  logic       leftReq, rightReq, rotReq, dropTick, spawnValid, canMove;
  logic [3:0] spawnBlock;
`ifdef HARD_DROP_EN
  logic       hardDropReq;
`endif
  logic       checkEnable;
  logic [1:0] checkDir;
  logic [3:0] checkBlock;
  logic [3:0] XPOS;
  logic [4:0] YPOS;
  logic [3:0] currentBlock;
  logic       lockPulse;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  piece_move_controller #(.SPAWN_X(SPAWN_X), .MAX_Y(MAX_Y)) dut (
    .Clock(Clock), .Reset(Reset),
    .leftReq(leftReq), .rightReq(rightReq), .rotReq(rotReq), .dropTick(dropTick),
    .spawnValid(spawnValid), .spawnBlock(spawnBlock), .canMove(canMove),
`ifdef HARD_DROP_EN
    .hardDropReq(hardDropReq),
`endif
    .checkEnable(checkEnable), .checkDir(checkDir), .checkBlock(checkBlock),
    .XPOS(XPOS), .YPOS(YPOS), .currentBlock(currentBlock),
    .lockPulse(lockPulse), .busy(busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- behavioural model ----------------
  int rot_tab [16] = '{1, 0, 2, 4, 3, 6, 7, 8, 5, 10, 11, 12, 9, 14, 13, 15};
  int m_x, m_y, m_blk, m_phase, m_op, m_cblk;
  bit m_hard;
  bit want_drop, want_left, want_right, want_rot, want_hard;

  task automatic model_step();
    bit d, l, r, t, h;
    if (Reset) begin
      m_x = SPAWN_X; m_y = 0; m_blk = 0; m_phase = PH_SPAWN;
      m_op = 0; m_cblk = 0; m_hard = 1'b0;
      want_drop = 0; want_left = 0; want_right = 0; want_rot = 0; want_hard = 0;
      return;
    end
    d = want_drop | dropTick;
    l = want_left | leftReq;
    r = want_right | rightReq;
    t = want_rot | rotReq;
`ifdef HARD_DROP_EN
    h = want_hard | hardDropReq;
`else
    h = want_hard;
`endif
    case (m_phase)
      PH_SPAWN: if (spawnValid) begin
        m_blk = int'(spawnBlock); m_x = SPAWN_X; m_y = 0;
        d = 0; l = 0; r = 0; t = 0; h = 0; m_hard = 0;
        m_phase = PH_IDLE;
      end
      PH_LAND: m_phase = PH_SPAWN;
      PH_IDLE: begin
        if (h || d) begin
          if (m_y == MAX_Y) begin
            if (h) h = 0; else d = 0;
            m_phase = PH_LAND;
          end else begin
            m_op = 0; m_hard = h; m_cblk = m_blk; m_phase = PH_CHECK;
          end
        end else if (t) begin
          m_op = 3; m_hard = 0; m_cblk = rot_tab[m_blk]; m_phase = PH_CHECK;
        end else if (l && r) begin
          l = 0; r = 0;
        end else if (l) begin
          m_op = 1; m_hard = 0; m_cblk = m_blk; m_phase = PH_CHECK;
        end else if (r) begin
          m_op = 2; m_hard = 0; m_cblk = m_blk; m_phase = PH_CHECK;
        end
      end
      PH_CHECK: begin
        if (m_hard) h = 0;
        else if (m_op == 0) d = 0;
        else if (m_op == 1) l = 0;
        else if (m_op == 2) r = 0;
        else t = 0;
        m_phase = PH_VERD;
      end
      PH_VERD: begin
        if (canMove) begin
          if (m_op == 0 && m_y < MAX_Y) m_y++;
          if (m_op == 1 && m_x > 0) m_x--;
          if (m_op == 2 && m_x < MAX_X) m_x++;
          if (m_op == 3) m_blk = rot_tab[m_blk];
          if (m_hard) m_phase = (m_y == MAX_Y) ? PH_LAND : PH_CHECK;
          else m_phase = PH_IDLE;
        end else begin
          m_phase = (m_op == 0) ? PH_LAND : PH_IDLE;
        end
      end
      default: m_phase = PH_SPAWN;
    endcase
    want_drop = d; want_left = l; want_right = r; want_rot = t; want_hard = h;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("xpos", 32'(XPOS), m_x);
    chk("ypos", 32'(YPOS), m_y);
    chk("block", 32'(currentBlock), m_blk);
    chk("check_en", 32'(checkEnable), (m_phase == PH_CHECK) ? 1 : 0);
    chk("lock", 32'(lockPulse), (m_phase == PH_LAND) ? 1 : 0);
    chk("busy", 32'(busy), (m_phase != PH_IDLE) ? 1 : 0);
    if (m_phase == PH_CHECK) begin
      chk("check_dir", 32'(checkDir), m_op);
      chk("check_blk", 32'(checkBlock), m_cblk);
    end
  endtask

  // One clock: inputs set before it are sampled at the rising edge; the model
  // advances and the outputs are compared on the falling edge.
  task automatic tick();
    @(negedge Clock);
    model_step();
    compare_all();
  endtask

  task automatic clear_inputs();
    leftReq = 0; rightReq = 0; rotReq = 0; dropTick = 0; spawnValid = 0;
`ifdef HARD_DROP_EN
    hardDropReq = 0;
`endif
  endtask

  task automatic random_phase(input int cycles, input int w_drop, input int w_left,
                              input int w_right, input int w_rot, input int w_can);
    for (int i = 0; i < cycles; i++) begin
      Reset      = ($urandom_range(0, 599) == 0);
      dropTick   = ($urandom_range(0, 99) < w_drop);
      leftReq    = ($urandom_range(0, 99) < w_left);
      rightReq   = ($urandom_range(0, 99) < w_right);
      rotReq     = ($urandom_range(0, 99) < w_rot);
`ifdef HARD_DROP_EN
      hardDropReq = ($urandom_range(0, 59) == 0);
`endif
      spawnValid = ($urandom_range(0, 2) == 0);
      spawnBlock = 4'($urandom_range(0, 15));
      canMove    = ($urandom_range(0, 99) < w_can);
      tick();
    end
    Reset = 0;
    clear_inputs();
  endtask

  initial begin
`ifdef HARD_DROP_EN
    int n_hd;
`endif
    Reset = 1; canMove = 0; spawnBlock = 0;
    clear_inputs();

    // Reset values
    tick(); tick();
    chk("rst_busy", 32'(busy), 1);
    chk("rst_xpos", 32'(XPOS), 6);
    chk("rst_ypos", 32'(YPOS), 0);
    chk("rst_block", 32'(currentBlock), 0);
    chk("rst_check_en", 32'(checkEnable), 0);
    chk("rst_check_dir", 32'(checkDir), 0);
    chk("rst_check_blk", 32'(checkBlock), 0);
    chk("rst_lock", 32'(lockPulse), 0);
    Reset = 0;
    tick();
    chk("spawn_wait_busy", 32'(busy), 1);

    // Spawn block 9
    spawnValid = 1; spawnBlock = 4'd9; tick(); spawnValid = 0;
    chk("spawn_x", 32'(XPOS), 6);
    chk("spawn_y", 32'(YPOS), 0);
    chk("spawn_blk", 32'(currentBlock), 9);
    chk("spawn_busy", 32'(busy), 0);

    // Left move, 3-cycle latency
    leftReq = 1; tick(); leftReq = 0;
    chk("left_issue_en", 32'(checkEnable), 1);
    chk("left_issue_dir", 32'(checkDir), 1);
    canMove = 1; tick(); tick();
    chk("left_commit_x", 32'(XPOS), 5);

    // Failed gravity -> lock pulse, then wait for spawn
    dropTick = 1; canMove = 0; tick(); dropTick = 0;
    chk("drop_issue_dir", 32'(checkDir), 0);
    tick(); tick();
    chk("lock_pulse", 32'(lockPulse), 1);
    tick();
    chk("lock_once", 32'(lockPulse), 0);
    chk("spawn_busy_after_lock", 32'(busy), 1);
    tick();
    chk("spawn_hold_busy", 32'(busy), 1);
    spawnValid = 1; spawnBlock = 4'd8; tick(); spawnValid = 0;
    chk("respawn_blk", 32'(currentBlock), 8);

    // Rotation of block 8: rejected then accepted
    rotReq = 1; canMove = 0; tick(); rotReq = 0;
    chk("rot_check_blk", 32'(checkBlock), 5);
    chk("rot_check_dir", 32'(checkDir), 3);
    tick(); tick();
    chk("rot_reject_blk", 32'(currentBlock), 8);
    rotReq = 1; tick(); rotReq = 0; canMove = 1; tick(); tick();
    chk("rot_accept_blk", 32'(currentBlock), 5);

    // Drop and left together: down first, then left
    dropTick = 1; leftReq = 1; tick(); dropTick = 0; leftReq = 0;
    chk("pair_first_dir", 32'(checkDir), 0);
    tick(); tick();
    chk("pair_down_y", 32'(YPOS), 1);
    tick();
    chk("pair_second_dir", 32'(checkDir), 1);
    tick(); tick();
    chk("pair_left_x", 32'(XPOS), 5);
    chk("pair_y_kept", 32'(YPOS), 1);

    // Left and right together cancel
    leftReq = 1; rightReq = 1; tick(); leftReq = 0; rightReq = 0;
    chk("cancel_no_check", 32'(checkEnable), 0);
    chk("cancel_idle", 32'(busy), 0);
    tick(); tick(); tick();
    chk("cancel_x", 32'(XPOS), 5);

`ifdef HARD_DROP_EN
    // Hard drop: four successful down-checks, fifth fails
    Reset = 1; tick(); Reset = 0;
    spawnValid = 1; spawnBlock = 4'd2; tick(); spawnValid = 0;
    hardDropReq = 1; tick(); hardDropReq = 0;
    n_hd = 0;
    for (int i = 0; i < 60 && lockPulse !== 1'b1; i++) begin
      if (checkEnable === 1'b1) begin
        n_hd++;
        canMove = (n_hd < 5);
      end
      tick();
    end
    chk("hd_lock", 32'(lockPulse), 1);
    chk("hd_y", 32'(YPOS), 4);
    chk("hd_checks", n_hd, 5);
`endif

    // Random traffic, then floor-reaching and edge-saturating mixes
    random_phase(3000, 15, 15, 15, 15, 75);
    random_phase(1500, 50, 5, 5, 5, 100);
    random_phase(800, 2, 60, 5, 5, 100);
    random_phase(800, 2, 5, 60, 5, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
